// File: rtl/red_pitaya_bus_initiator.sv
// System-bus initiator: queues commands in a small FIFO and runs them one at a
// time as single-strobe bus transactions, returning one response per command.
module red_pitaya_bus_initiator #(
  parameter int unsigned LOG_DEPTH = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  // command port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_sel,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_status,
  // system bus
  output logic [31:0]          sys_addr,
  output logic [31:0]          sys_wdata,
  output logic [3:0]           sys_sel,
  output logic                 sys_wen,
  output logic                 sys_ren,
  input  logic [31:0]          sys_rdata,
  input  logic                 sys_err,
  input  logic                 sys_ack,
  // status
  output logic                 busy,
  output logic [LOG_DEPTH:0]   fifo_level
);

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [LOG_DEPTH:0] LEVEL_FULL = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  cmd_t                 mem [DEPTH];
  cmd_t                 head;
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 cur_we, cur_we_n;
  logic [31:0]          addr_n, wdata_n, rdata_n;
  logic [3:0]           sel_n;
  logic                 wen_n, ren_n;
  logic [1:0]           status_n;

  assign full      = (fifo_level == LEVEL_FULL);
  assign empty     = (fifo_level == '0);
  assign cmd_ready = rstn_i & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_IDLE) & ~empty;
  assign head      = mem[rd_ptr];
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) | ~empty;

  // FIFO storage; contents are don't-care until written, pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, sel: cmd_sel};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (LOG_DEPTH + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (LOG_DEPTH + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Transaction FSM state and registered bus/response outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur_we     <= 1'b0;
      sys_addr   <= '0;
      sys_wdata  <= '0;
      sys_sel    <= '0;
      sys_wen    <= 1'b0;
      sys_ren    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cur_we     <= cur_we_n;
      sys_addr   <= addr_n;
      sys_wdata  <= wdata_n;
      sys_sel    <= sel_n;
      sys_wen    <= wen_n;
      sys_ren    <= ren_n;
      rsp_rdata  <= rdata_n;
      rsp_status <= status_n;
    end
  end

  // Next-state logic; ack/err only matter in WAIT since responders register them
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_we_n = cur_we;
    addr_n   = sys_addr;
    wdata_n  = sys_wdata;
    sel_n    = sys_sel;
    wen_n    = 1'b0;
    ren_n    = 1'b0;
    rdata_n  = rsp_rdata;
    status_n = rsp_status;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_n  = S_ISSUE;
          cur_we_n = head.we;
          addr_n   = head.addr;
          wdata_n  = head.wdata;
          sel_n    = head.sel;
          wen_n    = head.we;
          ren_n    = ~head.we;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        if (sys_err) begin
          state_n  = S_RESP;
          rdata_n  = '0;
          status_n = ST_ERR;
        end else if (sys_ack) begin
          state_n  = S_RESP;
          rdata_n  = cur_we ? 32'h0 : sys_rdata;
          status_n = ST_OK;
        end else if (cnt == CNT_LAST) begin
          state_n  = S_RESP;
          rdata_n  = '0;
          status_n = ST_TMO;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_red_pitaya_bus_initiator.sv
// Self-checking bench: randomized commands against a queue-based response model
// and a scripted bus responder.
module tb_red_pitaya_bus_initiator;

  localparam int unsigned TMO = 8;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          kind;
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_err, sys_ack;
  logic        busy;
  logic [2:0]  fifo_level;

  int    tests = 0;
  int    failed = 0;
  int    n_strobes = 0;
  int    rsp_mode = 0;   // 0: hold rsp_ready low, 1: high, 2: random
  plan_t plan_q[$];
  rsp_t  exp_q[$];

  red_pitaya_bus_initiator #(.LOG_DEPTH(2), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk_i = ~clk_i;

  // Expected response derived from how the responder will treat the command
  function automatic rsp_t expect_of(input plan_t p);
    rsp_t r;
    if (p.kind == K_NONE) begin
      r.rdata = 32'h0; r.status = 2'b10;
    end else if (p.kind == K_ERR || p.kind == K_BOTH) begin
      r.rdata = 32'h0; r.status = 2'b01;
    end else begin
      r.rdata = p.we ? 32'h0 : p.rdata; r.status = 2'b00;
    end
    return r;
  endfunction

  function automatic plan_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int kind, input int delay,
                               input logic [31:0] rdata);
    plan_t p;
    p.we = we; p.addr = addr; p.wdata = wdata; p.sel = sel;
    p.kind = kind; p.delay = delay; p.rdata = rdata;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    int k;
    int r;
    r = int'($urandom_range(0, 9));
    k = (r <= 5) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_BOTH : K_NONE;
    return mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              k, int'($urandom_range(1, 5)), $urandom);
  endfunction

  task automatic drive_cmd(input plan_t p);
    cmd_we = p.we; cmd_addr = p.addr; cmd_wdata = p.wdata; cmd_sel = p.sel;
  endtask

  // Offer one command from a negedge; returns at the negedge after acceptance
  task automatic push(input plan_t p);
    int n;
    n = 0;
    drive_cmd(p);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      tests++; failed++;
      $display("FAIL push_accept: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    plan_q.push_back(p);
    exp_q.push_back(expect_of(p));
    @(negedge clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || plan_q.size() != 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL drain: pending_rsp=%0d pending_cmd=%0d busy=%b required 0/0/0",
               exp_q.size(), plan_q.size(), busy);
    end
  endtask

  // Bus responder: checks each strobe against the next planned command, then
  // acks/errs after the planned delay or stays silent for a timeout.
  initial begin : responder
    plan_t p;
    int    wait_n;
    bit    aborted;
    sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = 32'h0;
    forever begin
      @(negedge clk_i);
      if (rstn_i === 1'b1 && (sys_wen === 1'b1 || sys_ren === 1'b1)) begin
        n_strobes++;
        tests++;
        if (plan_q.size() == 0) begin
          failed++;
          $display("FAIL strobe_unexpected: wen=%b ren=%b addr=%h with no queued command",
                   sys_wen, sys_ren, sys_addr);
        end else begin
          p = plan_q.pop_front();
          if (sys_wen !== p.we || sys_ren !== !p.we || sys_addr !== p.addr ||
              sys_wdata !== p.wdata || sys_sel !== p.sel) begin
            failed++;
            $display("FAIL strobe_fields: wen=%b ren=%b addr=%h wdata=%h sel=%h required %b %b %h %h %h",
                     sys_wen, sys_ren, sys_addr, sys_wdata, sys_sel,
                     p.we, !p.we, p.addr, p.wdata, p.sel);
          end
          wait_n  = (p.kind == K_NONE) ? int'(TMO) : p.delay;
          aborted = 1'b0;
          for (int i = 1; i <= wait_n; i++) begin
            @(negedge clk_i);
            if (rstn_i !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            tests++;
            if (sys_wen !== 1'b0 || sys_ren !== 1'b0 || rsp_valid !== 1'b0 ||
                sys_addr !== p.addr || sys_wdata !== p.wdata) begin
              failed++;
              $display("FAIL wait_cycle%0d: wen=%b ren=%b rsp_valid=%b addr=%h required 0 0 0 %h",
                       i, sys_wen, sys_ren, rsp_valid, sys_addr, p.addr);
            end
            if (i == wait_n && p.kind != K_NONE) begin
              sys_ack   = (p.kind == K_ACK || p.kind == K_BOTH);
              sys_err   = (p.kind == K_ERR || p.kind == K_BOTH);
              sys_rdata = p.rdata;
            end
          end
          if (!aborted) begin
            @(negedge clk_i);
            sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = $urandom;
            if (rstn_i === 1'b1) begin
              tests++;
              if (rsp_valid !== 1'b1) begin
                failed++;
                $display("FAIL rsp_latency: rsp_valid=%b required 1 one cycle after ack/timeout",
                         rsp_valid);
              end
            end
          end else begin
            sys_ack = 1'b0; sys_err = 1'b0;
          end
        end
      end
    end
  end

  // Response consumer: drives rsp_ready, checks order, values and stability
  initial begin : consumer
    rsp_t        e;
    bit          holding;
    logic [31:0] h_rdata;
    logic [1:0]  h_status;
    holding   = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk_i);
      rsp_ready = (rsp_mode == 1) ? 1'b1 : (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rstn_i !== 1'b1) begin
        holding = 1'b0;
      end else if (rsp_valid === 1'b1) begin
        if (holding) begin
          tests++;
          if (rsp_rdata !== h_rdata || rsp_status !== h_status) begin
            failed++;
            $display("FAIL rsp_stable: rdata=%h status=%b required %h %b",
                     rsp_rdata, rsp_status, h_rdata, h_status);
          end
        end
        if (rsp_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL rsp_unexpected: rdata=%h status=%b with no outstanding command",
                     rsp_rdata, rsp_status);
          end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_status !== e.status) begin
              failed++;
              $display("FAIL rsp_value: rdata=%h status=%b required %h %b",
                       rsp_rdata, rsp_status, e.rdata, e.status);
            end
          end
          holding = 1'b0;
        end else begin
          holding  = 1'b1;
          h_rdata  = rsp_rdata;
          h_status = rsp_status;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic test_reset();
    #1;
    tests++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || sys_wen !== 1'b0 || sys_ren !== 1'b0 ||
        fifo_level !== 3'd0 || busy !== 1'b0 || sys_addr !== 32'h0 || rsp_status !== 2'b00 ||
        rsp_rdata !== 32'h0) begin
      failed++;
      $display("FAIL reset_state: ready=%b rsp_valid=%b wen=%b ren=%b level=%0d busy=%b addr=%h required all 0",
               cmd_ready, rsp_valid, sys_wen, sys_ren, fifo_level, busy, sys_addr);
    end
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    tests++;
    if (cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL ready_after_reset: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_mode = 1;
    push(mk(1'b1, 32'h4030_0000, 32'h0000_000B, 4'hF, K_ACK, 1, 32'hDEAD_BEEF));
    tests++;
    if (sys_wen !== 1'b0 || fifo_level !== 3'd1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL write_queued: wen=%b level=%0d busy=%b required 0 1 1", sys_wen, fifo_level, busy);
    end
    @(negedge clk_i);
    tests++;
    if (sys_wen !== 1'b1 || sys_addr !== 32'h4030_0000 || sys_wdata !== 32'hB || fifo_level !== 3'd0) begin
      failed++;
      $display("FAIL write_strobe: wen=%b addr=%h wdata=%h level=%0d required 1 40300000 0000000b 0",
               sys_wen, sys_addr, sys_wdata, fifo_level);
    end
    drain();
  endtask

  task automatic test_read();
    rsp_mode = 2;
    push(mk(1'b0, 32'h4035_0004, $urandom, 4'hF, K_ACK, 3, 32'h0000_0002));
    drain();
  endtask

  task automatic test_timeout();
    rsp_mode = 1;
    push(mk(1'b0, $urandom, $urandom, 4'hF, K_NONE, 1, $urandom));
    drain();
    push(mk(1'b0, $urandom, $urandom, 4'h3, K_ACK, 1, $urandom));
    drain();
  endtask

  task automatic test_err_priority();
    rsp_mode = 1;
    push(mk(1'b0, $urandom, $urandom, 4'hF, K_BOTH, 2, $urandom));
    drain();
    push(mk(1'b1, $urandom, $urandom, 4'hC, K_ERR, 1, $urandom));
    drain();
  endtask

  task automatic test_stray();
    rsp_mode = 1;
    sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = $urandom;
    repeat (3) @(negedge clk_i);
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || sys_wen !== 1'b0 || sys_ren !== 1'b0) begin
      failed++;
      $display("FAIL stray_idle: rsp_valid=%b busy=%b wen=%b ren=%b required 0 0 0 0",
               rsp_valid, busy, sys_wen, sys_ren);
    end
    sys_ack = 1'b0; sys_err = 1'b0;
  endtask

  task automatic test_fifo_full();
    plan_t f;
    int    s0;
    int    n;
    rsp_mode = 0;
    push(mk(1'b0, $urandom, $urandom, 4'hF, K_ACK, 1, $urandom));
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    s0 = n_strobes;
    for (int i = 0; i < 4; i++) push(rand_plan());
    tests++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL fifo_full: level=%0d cmd_ready=%b required 4 0", fifo_level, cmd_ready);
    end
    f = rand_plan();
    drive_cmd(f);
    cmd_valid = 1'b1;
    repeat (6) @(negedge clk_i);
    cmd_valid = 1'b0;
    tests++;
    if (fifo_level !== 3'd4 || n_strobes != s0 || rsp_valid !== 1'b1) begin
      failed++;
      $display("FAIL backpressure: level=%0d strobes=%0d rsp_valid=%b required 4 %0d 1",
               fifo_level, n_strobes, rsp_valid, s0);
    end
    rsp_mode = 1;
    n = 0;
    while (fifo_level === 3'd4 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    tests++;
    if (fifo_level !== 3'd3 || cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL first_pop: level=%0d cmd_ready=%b required 3 1", fifo_level, cmd_ready);
    end
    push(f);
    rsp_mode = 2;
    drain();
  endtask

  task automatic test_random();
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) push(rand_plan());
    drain();
  endtask

  task automatic test_reset_mid_wait();
    int s0;
    int n;
    rsp_mode = 1;
    s0 = n_strobes;
    push(mk(1'b0, $urandom, $urandom, 4'hF, K_NONE, 1, $urandom));
    n = 0;
    while (n_strobes == s0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    push(mk(1'b1, $urandom, $urandom, 4'hF, K_ACK, 1, $urandom));
    tests++;
    if (fifo_level !== 3'd1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset: level=%0d busy=%b required 1 1", fifo_level, busy);
    end
    #2 rstn_i = 1'b0;
    #1;
    tests++;
    if (sys_wen !== 1'b0 || sys_ren !== 1'b0 || rsp_valid !== 1'b0 || fifo_level !== 3'd0 ||
        busy !== 1'b0 || cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: wen=%b ren=%b rsp_valid=%b level=%0d busy=%b ready=%b required all 0",
               sys_wen, sys_ren, rsp_valid, fifo_level, busy, cmd_ready);
    end
    repeat (3) @(negedge clk_i);
    plan_q.delete();
    exp_q.delete();
    rstn_i = 1'b1;
    repeat (4) @(negedge clk_i);
    push(mk(1'b0, $urandom, $urandom, 4'h5, K_ACK, 2, $urandom));
    drain();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    rstn_i = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_err_priority();
    test_stray();
    test_fifo_full();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
